// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
//   Execute-stage branch resolution and fetch PC ownership. Resolves conditional
//   branches (using the comparator result), JAL and JALR; redirects the fetch
//   PC with a one-cycle flush pulse; traps on targets that are not 4-byte
//   aligned and waits for the trap handler before jumping to TRAP_VECTOR.
//   Also counts executed and taken conditional branches.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   stall         global hold, freezes every register including FSM state
//   exe_valid     execute slot holds a valid instruction
//   is_branch_de  conditional branch in execute
//   is_jal_de     JAL in execute
//   is_jalr_de    JALR in execute
//   comp_out      comparator result, 1 = branch condition true
//   pc_de         PC of the execute instruction
//   imm_de        sign-extended immediate
//   rs1data_de    rs1 operand, JALR base address
//   trap_ack      trap handler accepts the pending trap
//   pc_fetch      registered fetch PC
//   flush         registered one-cycle kill of younger instructions
//   link_data     pc_de + 4, combinational return address for JAL/JALR
//   trap          registered misaligned-target trap, held until acknowledged
//   trap_addr     registered offending target address
//   br_cnt        executed conditional branches (wraps)
//   taken_cnt     taken conditional branches (wraps)
// -----------------------------------------------------------------------------
module branch_pc_unit #(
   parameter int unsigned          XLEN         = 32,
   parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'('h100)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            exe_valid,
   input  logic            is_branch_de,
   input  logic            is_jal_de,
   input  logic            is_jalr_de,
   input  logic            comp_out,
   input  logic [XLEN-1:0] pc_de,
   input  logic [XLEN-1:0] imm_de,
   input  logic [XLEN-1:0] rs1data_de,
   input  logic            trap_ack,
   output logic [XLEN-1:0] pc_fetch,
   output logic            flush,
   output logic [XLEN-1:0] link_data,
   output logic            trap,
   output logic [XLEN-1:0] trap_addr,
   output logic [31:0]     br_cnt,
   output logic [31:0]     taken_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      TRAP  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc_nxt, trap_addr_nxt;
   logic            flush_nxt, trap_nxt;
   logic [31:0]     br_cnt_nxt, taken_cnt_nxt;

   logic            take;
   logic            misaligned;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] jalr_sum;

   assign link_data = pc_de + XLEN'(4);
   assign jalr_sum  = rs1data_de + imm_de;
   assign take      = is_jal_de | is_jalr_de | (is_branch_de & comp_out);

   // JALR wins over JAL/branch if several decode flags are ever set at once.
   assign target     = is_jalr_de ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_de + imm_de);
   // No compressed ISA, so only bit 1 can misalign a target (bit 0 is even by construction).
   assign misaligned = target[1];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
      state_nxt     = state;
      pc_nxt        = pc_fetch;
      flush_nxt     = 1'b0;
      trap_nxt      = trap;
      trap_addr_nxt = trap_addr;
      br_cnt_nxt    = br_cnt;
      taken_cnt_nxt = taken_cnt;

      unique case (state)
         RUN: begin
            if (exe_valid && is_branch_de) begin
               br_cnt_nxt = br_cnt + 32'd1;
               if (comp_out) taken_cnt_nxt = taken_cnt + 32'd1;
            end
            if (exe_valid && take && !misaligned) begin
               pc_nxt    = target;
               flush_nxt = 1'b1;
               state_nxt = FLUSH;
            end else if (exe_valid && take) begin
               trap_nxt      = 1'b1;
               trap_addr_nxt = target;
               state_nxt     = TRAP;
            end else begin
               pc_nxt = pc_fetch + XLEN'(4);
            end
         end
         // The slot behind a redirect is wrong-path: exe_valid is ignored.
         FLUSH: begin
            pc_nxt    = pc_fetch + XLEN'(4);
            state_nxt = RUN;
         end
         TRAP: begin
            if (trap_ack) begin
               pc_nxt    = TRAP_VECTOR;
               trap_nxt  = 1'b0;
               flush_nxt = 1'b1;
               state_nxt = FLUSH;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         pc_fetch  <= RESET_VECTOR;
         flush     <= 1'b0;
         trap      <= 1'b0;
         trap_addr <= '0;
         br_cnt    <= '0;
         taken_cnt <= '0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
         state     <= state_nxt;
         pc_fetch  <= pc_nxt;
         flush     <= flush_nxt;
         trap      <= trap_nxt;
         trap_addr <= trap_addr_nxt;
         br_cnt    <= br_cnt_nxt;
         taken_cnt <= taken_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_unit
//   Directed self-checking bench for branch_pc_unit. Inputs change 1 ns after
//   the rising edge; outputs are sampled there too, well away from the edge.
// -----------------------------------------------------------------------------
module tb_branch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, exe_valid, is_branch_de, is_jal_de, is_jalr_de, comp_out, trap_ack;
   logic [31:0] pc_de, imm_de, rs1data_de;
   logic [31:0] pc_fetch, link_data, trap_addr, br_cnt, taken_cnt;
   logic        flush, trap;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_pc_unit dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .exe_valid    (exe_valid),
      .is_branch_de (is_branch_de),
      .is_jal_de    (is_jal_de),
      .is_jalr_de   (is_jalr_de),
      .comp_out     (comp_out),
      .pc_de        (pc_de),
      .imm_de       (imm_de),
      .rs1data_de   (rs1data_de),
      .trap_ack     (trap_ack),
      .pc_fetch     (pc_fetch),
      .flush        (flush),
      .link_data    (link_data),
      .trap         (trap),
      .trap_addr    (trap_addr),
      .br_cnt       (br_cnt),
      .taken_cnt    (taken_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exe_valid = 0; is_branch_de = 0; is_jal_de = 0; is_jalr_de = 0; comp_out = 0;
   endtask

   task automatic check_regs(input string tag, input logic [31:0] pc, input logic fl,
                             input logic tr, input logic [31:0] br, input logic [31:0] tk);
      check({tag, ".pc"},    pc_fetch,  pc);
      check({tag, ".flush"}, {31'b0, flush}, {31'b0, fl});
      check({tag, ".trap"},  {31'b0, trap},  {31'b0, tr});
      check({tag, ".br"},    br_cnt,    br);
      check({tag, ".taken"}, taken_cnt, tk);
   endtask

   initial begin
      rst = 1; stall = 0; trap_ack = 0;
      pc_de = 0; imm_de = 0; rs1data_de = 0;
      idle();
      #2;
      check_regs("reset", 32'h0, 0, 0, 0, 0);
      check("reset.trap_addr", trap_addr, 32'h0);
      @(posedge clk); #1 rst = 0;

      // 1: sequential fetch with no valid instruction
      step(); check_regs("seq1", 32'h4, 0, 0, 0, 0);
      step(); check_regs("seq2", 32'h8, 0, 0, 0, 0);
      step(); check_regs("seq3", 32'hC, 0, 0, 0, 0);

      // 2: taken BEQ 0x40 + 0x20
      exe_valid = 1; is_branch_de = 1; comp_out = 1; pc_de = 32'h40; imm_de = 32'h20;
      step(); check_regs("beq", 32'h60, 1, 0, 1, 1);
      // wrong-path slot: a valid taken branch here must be ignored entirely
      step(); check_regs("beq_shadow", 32'h64, 0, 0, 1, 1);

      // 3: not-taken BNE
      comp_out = 0; pc_de = 32'h64; imm_de = 32'h80;
      step(); check_regs("bne", 32'h68, 0, 0, 2, 1);

      // 4: JALR, bit 0 of target cleared
      idle(); exe_valid = 1; is_jalr_de = 1; pc_de = 32'h80; rs1data_de = 32'h1001; imm_de = 32'h10;
      #1 check("jalr.link", link_data, 32'h84);
      step(); check_regs("jalr", 32'h1010, 1, 0, 2, 1);
      idle();
      step(); check_regs("jalr_after", 32'h1014, 0, 0, 2, 1);

      // stall in RUN freezes the PC
      stall = 1;
      step(); check_regs("stall_run", 32'h1014, 0, 0, 2, 1);
      stall = 0;

      // 5: misaligned JAL -> trap
      exe_valid = 1; is_jal_de = 1; pc_de = 32'h40; imm_de = 32'h2;
      #1 check("jal.link", link_data, 32'h44);
      step(); check_regs("jal_trap", 32'h1014, 0, 1, 2, 1);
      check("jal_trap.addr", trap_addr, 32'h42);
      idle();
      step(); check_regs("trap_hold1", 32'h1014, 0, 1, 2, 1);
      step(); check_regs("trap_hold2", 32'h1014, 0, 1, 2, 1);

      // 6: stall beats trap_ack
      stall = 1; trap_ack = 1;
      step(); check_regs("trap_stall", 32'h1014, 0, 1, 2, 1);
      stall = 0;
      step(); check_regs("trap_ack", 32'h100, 1, 0, 2, 1);
      trap_ack = 0;
      stall = 1;
      step(); check_regs("flush_stall", 32'h100, 1, 0, 2, 1);
      stall = 0;
      step(); check_regs("flush_done", 32'h104, 0, 0, 2, 1);

      // misaligned taken branch counts as taken and traps
      exe_valid = 1; is_branch_de = 1; comp_out = 1; pc_de = 32'h40; imm_de = 32'h6;
      step(); check_regs("br_trap", 32'h104, 0, 1, 3, 2);
      check("br_trap.addr", trap_addr, 32'h46);
      idle();

      // asynchronous reset mid-TRAP, checked between clock edges
      #1 rst = 1;
      #1 check_regs("async_rst", 32'h0, 0, 0, 0, 0);
      check("async_rst.trap_addr", trap_addr, 32'h0);
      @(posedge clk); #1 rst = 0;
      step(); check_regs("post_rst", 32'h4, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
